// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin arbiter sharing one sigmoid LUT read port among NREQ gate units.
// Out-of-window phases bypass the LUT with a saturated result at the same latency.
module sigmoid_lut_arbiter #(
  parameter int NREQ    = 4,
  parameter int N       = 16,
  parameter int Q       = 12,
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int LUT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_phase,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     lut_addr,
  input  logic [DW-1:0]     lut_data,
  output logic [NREQ-1:0]   resp_valid,
  output logic [N-1:0]      resp_data,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int D  = LUT_LAT + 1;

  function automatic logic [N-1:0] sat_value(input logic neg);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1} << Q;
    return neg ? '0 : one;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [PW-1:0]        ptr;
  logic                 gnt_any;
  logic [PW-1:0]        gnt_idx;
  logic signed [N-1:0]  gnt_phase;
  logic [N-AW:0]        phase_top;
  logic                 in_win;

  logic                 vld_p    [D];
  logic [PW-1:0]        tag_p    [D];
  logic                 sat_p    [D];
  logic [N-1:0]         satval_p [D];

  // Arbitration: first valid requester at or after ptr, wrapping.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    gnt_phase = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any   = 1'b1;
        gnt_idx   = PW'(idx);
        gnt_phase = req_phase[idx*N +: N];
      end
    end
    req_ready = gnt_any ? onehot(gnt_idx) : '0;
  end

  // In window iff the phase fits an AW-bit signed value.
  assign phase_top = gnt_phase[N-1:AW-1];
  assign in_win    = (&phase_top) | ~(|phase_top);

  always_comb begin
    busy = |resp_valid;
    for (int i = 0; i < D; i++) busy = busy | vld_p[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      lut_addr   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      for (int i = 0; i < D; i++) begin
        vld_p[i]    <= 1'b0;
        tag_p[i]    <= '0;
        sat_p[i]    <= 1'b0;
        satval_p[i] <= '0;
      end
    end else begin
      // Stage 0: accept, drive LUT address, record tag and saturation.
      if (gnt_any) begin
        ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        if (in_win) lut_addr <= gnt_phase[AW-1:0];
      end
      vld_p[0]    <= gnt_any;
      tag_p[0]    <= gnt_idx;
      sat_p[0]    <= ~in_win;
      satval_p[0] <= sat_value(gnt_phase[N-1]);
      // Stages 1..LUT_LAT: wait out the LUT read latency.
      for (int i = 1; i < D; i++) begin
        vld_p[i]    <= vld_p[i-1];
        tag_p[i]    <= tag_p[i-1];
        sat_p[i]    <= sat_p[i-1];
        satval_p[i] <= satval_p[i-1];
      end
      // Retire: route the result to the issuing requester.
      resp_valid <= vld_p[D-1] ? onehot(tag_p[D-1]) : '0;
      if (vld_p[D-1]) resp_data <= sat_p[D-1] ? satval_p[D-1] : N'(lut_data);
    end
  end

endmodule

// File: doc/sigmoid_lut_arbiter.md
Name: sigmoid_lut_arbiter

Overview:
- Shares one sigmoid LUT read port among NREQ gate requesters (GRU/LSTM gate units) with a round-robin grant.
- Drives the LUT address and returns each result to the requester that issued it, with fixed latency.
- Saturates phases that fall outside the LUT address window, so no aliasing reads reach the LUT.
- Sits between the gate datapaths and a single sigmoid_lut instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N, 16, phase/result word width.
- Q, 12, fractional bits; 1.0 = 1<<Q.
- AW, 10, LUT address width; the LUT is addressed by phase[AW-1:0].
- DW, 16, LUT data width (DW = N).
- LUT_LAT, 1, LUT read latency in cycles, from lut_addr change to valid lut_data (0 = combinational).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request strobe per requester.
- req_phase  in  NREQ*N  packed signed phases; requester i uses bits [i*N +: N].
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] && req_ready[i].
- lut_addr  out  AW  registered address to the LUT.
- lut_data  in  DW  LUT read data.
- resp_valid  out  NREQ  one-hot, one-cycle result strobe.
- resp_data  out  N  result, shared by all requesters, qualified by resp_valid.
- busy  out  1  high while any accepted request has not yet been responded to.

Behaviour:
- Reset: rr pointer = 0, lut_addr = 0, resp_valid = 0, resp_data = 0, busy = 0, and all pipeline valid/tag/saturation stages cleared.
- Reset mid-operation: all in-flight requests are dropped with no response.
- Arbitration:
  - req_ready is combinational from req_valid and the rr pointer.
  - Grant goes to the first asserted req_valid at index ≥ ptr, wrapping to 0.
  - At most one grant per cycle; req_ready = 0 when no request is valid.
  - Requests are accepted every cycle back-to-back, with no stalls.
- Pointer update: on an accept from index g, ptr <= (g+1) mod NREQ. Otherwise ptr holds.
- Window check:
  - The phase is in-window iff bits [N-1:AW-1] are all equal, i.e. it fits in AW-bit signed.
  - Out-of-window positive phase → result ONE = 1<<Q (16'h1000 at defaults).
  - Out-of-window negative phase → result 0.
- Accept edge T:
  - lut_addr <= phase[AW-1:0] for in-window requests only; it holds otherwise.
  - A stage-0 entry {valid, tag = g, sat, satval} is pushed.
- Tag pipeline: a shift register of depth LUT_LAT+1, advancing every cycle.
- Response:
  - At edge T+1+LUT_LAT, resp_valid[tag] <= 1 and resp_data <= sat ? satval : lut_data.
  - resp_valid is 0 in every cycle with no retiring entry; resp_data holds its last value.
- Latency and ordering: fixed latency of 1+LUT_LAT cycles from accept to resp_valid, for both LUT and saturated results. Responses return in accept order.
- No response backpressure: requesters must sample resp_data in the cycle their resp_valid bit is high.
- busy = OR of all pipeline valid bits and resp_valid.
- Simultaneous events: a requester may assert a new req_valid in the same cycle it receives resp_valid, and may be re-granted under round-robin rules.
- A requester holding req_valid without being granted must keep req_phase stable.

Test Plan:
- Reset: assert rst mid-stream while two requests are in flight → resp_valid stays 0, ptr returns to 0, busy = 0, and no response arrives after release.
- Single request: requester 2 phase 16'h0005 alone, LUT_LAT = 1 → lut_addr = 10'h005 after accept edge; resp_valid = 4'b0100 exactly 2 cycles after accept; resp_data = mem[5].
- Round-robin: all four req_valid held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, no gaps.
- Saturation: requester 1 phase 16'h2000 → resp_data 16'h1000. Requester 3 phase 16'hE000 → resp_data 16'h0000. Both arrive at the same latency as LUT reads, and lut_addr is unchanged.
- Window edges: phases 16'h01FF and 16'hFE00 → LUT path, addresses 10'h1FF and 10'h200. Phases 16'h0200 and 16'hFDFF → saturate to 16'h1000 and 16'h0000.
- Wrap and sparse requests: ptr = 3 with only req 1 valid → grant 1, next ptr = 2. Then req 0 and req 2 both valid → grant 2 first, then 0. Repeat the 2-request test with LUT_LAT = 0 → latency 1.
